// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The counter must hold 2*width-1, the first iteration index.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(2 * width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift one dividend bit into the partial
// remainder, then conditionally subtract the divisor.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   partial_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] wide_divisor;
    logic           unused_msb;

    // The partial remainder is always below the divisor, so its top bit is zero
    // and the shift only needs the low WIDTH bits.
    assign unused_msb   = partial_rem[WIDTH];
    assign shifted      = {partial_rem[WIDTH-1:0], next_bit};
    assign wide_divisor = {1'b0, divisor};

    always_comb begin
        q_bit    = 1'b0;
        next_rem = shifted;
        if (shifted >= wide_divisor) begin
            q_bit    = 1'b1;
            next_rem = shifted - wide_divisor;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_FASTPATH_EN to finish divide-by-zero and dividend<divisor in one cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     rem_next;
    logic               q_bit;

    // work holds the dividend; each iteration shifts its MSB out into the
    // step and the new quotient bit in at the LSB, so after 2*WIDTH
    // iterations work contains the quotient.
    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem (rem),
        .next_bit    (work[2*WIDTH-1]),
        .divisor     (dvs),
        .next_rem    (rem_next),
        .q_bit       (q_bit)
    );

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; the producer holds data stable until then.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= dividend;
                        dvs  <= divisor;
                        rem  <= '0;
                        cnt  <= CW'(2 * WIDTH - 1);
`ifdef SEQ_DIVIDER_FASTPATH_EN
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else if (dividend < {{WIDTH{1'b0}}, divisor}) begin
                            quotient    <= '0;
                            remainder   <= dividend[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    work <= {work[2*WIDTH-2:0], q_bit};
                    rem  <= rem_next;
                    if (cnt == '0) begin
                        state <= DONE;
                        // Divide-by-zero iterations run normally and are replaced here.
                        if (dvs == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= {work[2*WIDTH-2:0], q_bit};
                            remainder   <= rem_next[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
